// File: rtl/hbridge_pkg.sv
// Shared codes for the H-bridge guard: FSM state encoding, decoded direction
// commands and latched fault reasons.
package hbridge_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_DRV_FWD = 3'd1;
   localparam logic [STATE_W-1:0] ST_DRV_REV = 3'd2;
   localparam logic [STATE_W-1:0] ST_DEAD    = 3'd3;
   localparam logic [STATE_W-1:0] ST_FAULT   = 3'd4;

   typedef enum logic [1:0] {
      CMD_STOP    = 2'd0,
      CMD_FWD     = 2'd1,
      CMD_REV     = 2'd2,
      CMD_ILLEGAL = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      FLT_NONE    = 2'd0,
      FLT_ILLEGAL = 2'd1,
      FLT_STUCK   = 2'd2
   } fault_e;

   // {b,a} lines up directly with the cmd_e encoding.
   function automatic cmd_e decode_cmd(input logic dir_a, input logic dir_b);
      return cmd_e'({dir_b, dir_a});
   endfunction

endpackage

// File: rtl/hbridge_guard_if.sv
// Control-side inputs and bridge-side outputs of the H-bridge guard.
// master = motor controller / test driver, slave = the guard itself.
interface hbridge_guard_if;

   logic       dir_a_in;
   logic       dir_b_in;
   logic       pwm_in;
   logic       enable_in;
   logic       fault_clr;
   logic       hb_in1;
   logic       hb_in2;
   logic       hb_en;
   logic [2:0] state_o;
   logic       fault;
   logic [1:0] fault_code;

   modport master (
      output dir_a_in, dir_b_in, pwm_in, enable_in, fault_clr,
      input  hb_in1, hb_in2, hb_en, state_o, fault, fault_code
   );

   modport slave (
      input  dir_a_in, dir_b_in, pwm_in, enable_in, fault_clr,
      output hb_in1, hb_in2, hb_en, state_o, fault, fault_code
   );

endinterface

// File: rtl/pwm_stuck_watchdog.sv
// Counts consecutive high PWM samples while armed; trips on the sample that
// makes the run reach STUCK_CYCLES. Counter saturates instead of wrapping.
module pwm_stuck_watchdog #(
   parameter int unsigned STUCK_CYCLES = 400000
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic arm,
   input  logic pwm_in,
   output logic trip
);

   localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [SW-1:0] LIMIT    = SW'(STUCK_CYCLES);
   localparam logic [SW-1:0] LIMIT_M1 = SW'(STUCK_CYCLES - 1);

   logic [SW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!arm || !pwm_in) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + SW'(1);
      end
   end

   // Combinational so the FSM leaves DRV on the very edge the run completes.
   assign trip = arm && pwm_in && (cnt_q >= LIMIT_M1);

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hbridge_guard.sv
// H-bridge pin driver: dead-time sequencing on stop/reversal, shoot-through
// blocking, illegal-direction and stuck-PWM fault latching.
module hbridge_guard
   import hbridge_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES      = 100000,
   parameter int unsigned PWM_STUCK_CYCLES = 400000
) (
   input  logic           PCLK,
   input  logic           PRESET,
   hbridge_guard_if.slave bus
);

   localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [DW-1:0]      dead_cnt_q, dead_cnt_d;
   fault_e             fault_code_q, fault_code_d;
   logic               hb_in1_q, hb_in2_q, hb_en_q, fault_q;

   cmd_e cmd;
   cmd_e own_cmd;
   logic drv_armed;
   logic drv_next;
   logic stuck_trip;

   assign cmd       = decode_cmd(bus.dir_a_in, bus.dir_b_in);
   assign drv_armed = (state_q == ST_DRV_FWD) || (state_q == ST_DRV_REV);
   assign own_cmd   = (state_q == ST_DRV_FWD) ? CMD_FWD : CMD_REV;
   assign drv_next  = (state_d == ST_DRV_FWD) || (state_d == ST_DRV_REV);

   pwm_stuck_watchdog #(
      .STUCK_CYCLES(PWM_STUCK_CYCLES)
   ) u_wdog (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .arm    (drv_armed),
      .pwm_in (bus.pwm_in),
      .trip   (stuck_trip)
   );

   always_comb begin
      state_d      = state_q;
      dead_cnt_d   = dead_cnt_q;
      fault_code_d = fault_code_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd == CMD_ILLEGAL) begin
               state_d      = ST_FAULT;
               fault_code_d = FLT_ILLEGAL;
            end else if (bus.enable_in && cmd == CMD_FWD) begin
               state_d = ST_DRV_FWD;
            end else if (bus.enable_in && cmd == CMD_REV) begin
               state_d = ST_DRV_REV;
            end
         end
         ST_DRV_FWD, ST_DRV_REV: begin
            // Priority: illegal > stuck > enable drop > direction change.
            if (cmd == CMD_ILLEGAL) begin
               state_d      = ST_FAULT;
               fault_code_d = FLT_ILLEGAL;
            end else if (stuck_trip) begin
               state_d      = ST_FAULT;
               fault_code_d = FLT_STUCK;
            end else if (!bus.enable_in || cmd != own_cmd) begin
               state_d    = ST_DEAD;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         ST_DEAD: begin
            // Commands other than ILLEGAL cannot shorten or restart the coast.
            if (cmd == CMD_ILLEGAL) begin
               state_d      = ST_FAULT;
               fault_code_d = FLT_ILLEGAL;
            end else if (dead_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               dead_cnt_d = dead_cnt_q - DW'(1);
            end
         end
         ST_FAULT: begin
            if (bus.fault_clr && cmd == CMD_STOP) begin
               state_d      = ST_DEAD;
               dead_cnt_d   = DEAD_LOAD;
               fault_code_d = FLT_NONE;
            end
         end
         default: begin
            state_d      = ST_DEAD;
            dead_cnt_d   = DEAD_LOAD;
            fault_code_d = FLT_NONE;
         end
      endcase
   end

   // Pins are registered from the next state, so each leg goes high only
   // from a state that is exclusive to it and never both at once.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= ST_DEAD;
         dead_cnt_q   <= DEAD_LOAD;
         fault_code_q <= FLT_NONE;
         hb_in1_q     <= 1'b0;
         hb_in2_q     <= 1'b0;
         hb_en_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         dead_cnt_q   <= dead_cnt_d;
         fault_code_q <= fault_code_d;
         hb_in1_q     <= (state_d == ST_DRV_FWD);
         hb_in2_q     <= (state_d == ST_DRV_REV);
         hb_en_q      <= drv_next && bus.pwm_in;
         fault_q      <= (state_d == ST_FAULT);
      end
   end

   assign bus.hb_in1     = hb_in1_q;
   assign bus.hb_in2     = hb_in2_q;
   assign bus.hb_en      = hb_en_q;
   assign bus.state_o    = state_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// Scoreboard bench for hbridge_guard: a mode-level reference model predicts
// every cycle's pins/state/fault; a negedge monitor pops and compares.
module tb_hbridge_guard;

   localparam int DEAD  = 4;
   localparam int STUCK = 10;

   typedef enum int {M_IDLE, M_FWD, M_REV, M_COAST, M_FAULT} mode_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   hbridge_guard_if bus ();

   hbridge_guard #(
      .DEAD_CYCLES      (DEAD),
      .PWM_STUCK_CYCLES (STUCK)
   ) dut (
      .PCLK   (clk),
      .PRESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [8:0] sb_q[$];

   mode_t m_mode     = M_COAST;
   int    coast_left = DEAD;
   int    m_code     = 0;
   int    high_run   = 0;

   // {in1, in2, en, fault, code[1:0], state[2:0]}
   localparam logic [8:0] RESET_EXP = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd3};

   function automatic logic [2:0] mode_code(input mode_t m);
      case (m)
         M_IDLE:  return 3'd0;
         M_FWD:   return 3'd1;
         M_REV:   return 3'd2;
         M_COAST: return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   task automatic model_step();
      bit a, b, p, e, c, ill, want_fwd, want_rev, stop, driving, leave;
      logic [8:0] exp_v;
      a = bus.dir_a_in; b = bus.dir_b_in; p = bus.pwm_in;
      e = bus.enable_in; c = bus.fault_clr;
      ill = a && b; want_fwd = a && !b; want_rev = !a && b; stop = !a && !b;
      driving = (m_mode == M_FWD) || (m_mode == M_REV);
      high_run = (driving && p) ? high_run + 1 : 0;
      case (m_mode)
         M_IDLE: begin
            if (ill) begin m_mode = M_FAULT; m_code = 1; end
            else if (e && want_fwd) m_mode = M_FWD;
            else if (e && want_rev) m_mode = M_REV;
         end
         M_FWD, M_REV: begin
            leave = !e || ((m_mode == M_FWD) ? !want_fwd : !want_rev);
            if (ill) begin m_mode = M_FAULT; m_code = 1; end
            else if (high_run >= STUCK) begin m_mode = M_FAULT; m_code = 2; end
            else if (leave) begin m_mode = M_COAST; coast_left = DEAD; end
         end
         M_COAST: begin
            if (ill) begin m_mode = M_FAULT; m_code = 1; end
            else if (coast_left == 1) m_mode = M_IDLE;
            else coast_left--;
         end
         default: begin
            if (c && stop) begin m_mode = M_COAST; coast_left = DEAD; m_code = 0; end
         end
      endcase
      exp_v = {m_mode == M_FWD, m_mode == M_REV,
               ((m_mode == M_FWD) || (m_mode == M_REV)) && p,
               m_mode == M_FAULT, 2'(m_code), mode_code(m_mode)};
      sb_q.push_back(exp_v);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
         if (rst) begin
            m_mode = M_COAST; coast_left = DEAD; m_code = 0; high_run = 0;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      logic [8:0] act, exp_v;
      forever begin
         @(negedge clk);
         act = {bus.hb_in1, bus.hb_in2, bus.hb_en, bus.fault, bus.fault_code, bus.state_o};
         total++;
         if (bus.hb_in1 && bus.hb_in2) begin
            bad++;
            $display("FAIL shoot_through cyc=%0d in1=%b in2=%b required never both high",
                     cycle, bus.hb_in1, bus.hb_in2);
         end
         total++;
         if (rst) begin
            sb_q.delete();
            if (act !== RESET_EXP) begin
               bad++;
               $display("FAIL reset_state cyc=%0d got=%b want=%b", cycle, act, RESET_EXP);
            end else begin
               $display("cyc=%0d reset ok %b", cycle, act);
            end
         end else if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty cyc=%0d got=%b want=<entry>", cycle, act);
         end else begin
            exp_v = sb_q.pop_front();
            if (act !== exp_v) begin
               bad++;
               $display("FAIL pins cyc=%0d got=%b want=%b (in1 in2 en flt code state)",
                        cycle, act, exp_v);
            end else begin
               $display("cyc=%0d ok %b", cycle, act);
            end
         end
      end
   end

   task automatic cyc(input logic a, input logic b, input logic p, input logic e, input logic c);
      bus.dir_a_in = a; bus.dir_b_in = b; bus.pwm_in = p;
      bus.enable_in = e; bus.fault_clr = c;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int hold, sel;
      logic a, b, e;
      bus.dir_a_in = 1'b1; bus.dir_b_in = 1'b0; bus.pwm_in = 1'b0;
      bus.enable_in = 1'b1; bus.fault_clr = 1'b0;
      #1;
      pulse_reset();
      // Reset release into FWD with toggling PWM.
      for (int i = 0; i < 12; i++) cyc(1, 0, 1'(i % 2), 1, 0);
      // Reversal.
      for (int i = 0; i < 12; i++) cyc(0, 1, 1'(i % 2), 1, 0);
      // Illegal in DRV_REV, clear with REV ignored, clear with STOP accepted.
      cyc(1, 1, 1, 1, 0); cyc(1, 1, 0, 1, 0);
      cyc(0, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);
      // Stuck-high PWM while driving forward.
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
      for (int i = 0; i < 13; i++) cyc(1, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);
      // 9 high + 1 low never trips.
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
      for (int i = 0; i < 50; i++) cyc(1, 0, 1'((i % 10) != 9), 1, 0);
      // Enable drop, then FWD requested during the coast.
      cyc(1, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 0, 1'(i % 2), 1, 0);
      // Asynchronous reset mid-drive.
      pulse_reset();
      for (int i = 0; i < 10; i++) cyc(1, 0, 1'(i % 2), 1, 0);
      // Randomized segments.
      for (int s = 0; s < 400; s++) begin
         sel  = int'($urandom_range(0, 9));
         hold = int'($urandom_range(1, 12));
         a = (sel <= 3) || (sel == 9);
         b = (sel >= 4 && sel <= 7) || (sel == 9);
         e = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < hold; i++)
            cyc(a, b, 1'($urandom_range(0, 9) != 0), e, 1'($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 79) == 0) pulse_reset();
      end
      cyc(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
